sm4_issue_ctrl: RTL and testbench
=================================

Name: sm4_issue_ctrl

Overview:
- Upstream issue/collect stage for the SM4 accelerator path, between the RV32IM EX stage and the SM4 datapath.
- Latches the 32-bit source operand of an accelerator instruction and drives it onto `msg_o`, which feeds `message_padding.message_in`.
- Pulses start to the SM4 core, stalls the pipeline while the core runs, then returns one selected 32-bit word of the 128-bit result with a one-cycle valid.
- A timeout counter guards against a hung core.

Parameters:
- `RESULT_WORD`, 0: ciphertext word returned. 0 = [31:0], 1 = [63:32], 2 = [95:64], 3 = [127:96].
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before abandoning the operation. Legal range 1..2^CNT_W.
- `CNT_W`, 8: width of the timeout counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_i`  in  1  accelerator instruction present in EX. Held high by the requester until the end of the `rvalid_o` cycle.
- `op_i`  in  32  source operand, sampled on acceptance.
- `flush_i`  in  1  pipeline flush; abort from any state.
- `busy_o`  out  1  stall request to the pipeline.
- `rvalid_o`  out  1  result valid, one-cycle pulse.
- `rdata_o`  out  32  result word. Meaningful only while `rvalid_o`=1.
- `err_o`  out  1  timeout flag, qualified by `rvalid_o`.
- `msg_o`  out  32  latched operand to `message_padding.message_in`.
- `core_start_o`  out  1  one-cycle start pulse to the SM4 core.
- `core_done_i`  in  1  SM4 core completion strobe.
- `core_block_i`  in  128  SM4 core result block, valid with `core_done_i`.

Behaviour:
- **Reset** (async, `rst_n`=0):
  - State = IDLE.
  - `msg_o`=0, `rdata_o`=0, counter=0.
  - `busy_o`=0, `rvalid_o`=0, `err_o`=0, `core_start_o`=0.
- **States:** IDLE, LAUNCH, WAIT, RESP. All outputs are registered except `busy_o`.
- **IDLE:**
  - `req_i`=1 and `flush_i`=0: capture `op_i` into `msg_o`, go to LAUNCH.
  - `busy_o` = `req_i` & ~`flush_i`, combinational, so the pipeline stalls in the acceptance cycle.
  - `core_done_i` is ignored (covers late done after a flush).
- **LAUNCH:**
  - `core_start_o`=1 for exactly this cycle.
  - Counter loaded with `TIMEOUT_CYCLES`-1.
  - `busy_o`=1.
  - `core_done_i` is ignored.
  - Next state WAIT.
- **WAIT:**
  - `busy_o`=1.
  - `core_done_i`=1: `rdata_o` <= selected word of `core_block_i`, `err_o` <= 0, go to RESP.
  - Else if counter==0: `rdata_o` <= 0, `err_o` <= 1, go to RESP.
  - Else: counter decrements.
  - Done and counter==0 in the same cycle: done wins, `err_o`=0.
- **RESP:**
  - `rvalid_o`=1, `busy_o`=0 (instruction retires this cycle), `rdata_o`/`err_o` held.
  - `req_i` is ignored.
  - Next state IDLE, with `rvalid_o`=0 and `err_o`=0.
- **Latency:**
  - Acceptance in cycle 0, `core_start_o` in cycle 1.
  - Done first sampled in cycle 2.
  - Done in cycle k gives `rvalid_o` in cycle k+1.
  - Minimum `rvalid_o` cycle is 3.
  - `busy_o` is high continuously from cycle 0 to cycle k.
- **`msg_o` stability:** constant from LAUNCH through RESP and into the following IDLE. It changes only on acceptance.
- **`flush_i`:** has priority in every state. Next state IDLE, `busy_o`=0 in that cycle, no `rvalid_o`, `msg_o` retained. A flush in RESP suppresses nothing already seen; `rvalid_o` is a single cycle either way.
- **Back-to-back:** a new request is accepted in the IDLE cycle after RESP if `req_i`=1. Throughput is at most one operation per 4 cycles.
- **Reset mid-operation:** immediate return to the reset values, including during WAIT.

Test Plan:
1. **Basic operation:** reset, then `req_i`=1 with `op_i`=0x01234567, `RESULT_WORD`=3. Core raises done 5 cycles after start with `core_block_i`=0x681EDF34_D206965E_86B3E94F_536E4246. Required: `core_start_o` one pulse in cycle 1; `msg_o`=0x01234567; `rvalid_o` in cycle 7 with `rdata_o`=0x681EDF34, `err_o`=0; `busy_o` high cycles 0-6.
2. **Timeout:** `TIMEOUT_CYCLES`=4, core never done. Required: `rvalid_o` in cycle 6 with `err_o`=1 and `rdata_o`=0; return to IDLE in cycle 7.
3. **Done/timeout collision:** done asserted exactly in the counter==0 WAIT cycle with block low word 0xDEADBEEF, `RESULT_WORD`=0. Required: `rdata_o`=0xDEADBEEF, `err_o`=0.
4. **Flush:** flush in WAIT cycle 3, then core done in cycle 5. Required: `busy_o` drops in cycle 3; no `rvalid_o`; late done ignored; next request with `op_i`=0xCAFEF00D is accepted normally.
5. **Back-to-back and early done:**
   - Two back-to-back requests (0x11111111, then 0x22222222): `msg_o` updates only at the second acceptance, two distinct `rvalid_o` pulses.
   - `core_done_i` asserted during LAUNCH: ignored.
6. **Async reset:** assert `rst_n`=0 mid-WAIT, between clock edges. Required: all outputs return to reset values immediately; no `rvalid_o` after release.

Source files
------------

// File: rtl/sm4_issue_ctrl.sv
// Issue/collect controller between the EX stage and the SM4 core: latches the operand,
// launches the core, stalls the pipeline and returns one word of the result block.
module sm4_issue_ctrl #(
    parameter int RESULT_WORD    = 0,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_i,
    input  logic [31:0]  op_i,
    input  logic         flush_i,
    output logic         busy_o,
    output logic         rvalid_o,
    output logic [31:0]  rdata_o,
    output logic         err_o,
    output logic [31:0]  msg_o,
    output logic         core_start_o,
    input  logic         core_done_i,
    input  logic [127:0] core_block_i
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       WORD_SEL = RESULT_WORD[1:0];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      msg_reg, msg_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic             rvalid_reg, rvalid_next;
    logic             err_reg, err_next;
    logic             start_reg, start_next;
    logic [31:0]      block_words [4];
    logic [31:0]      sel_word;

    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        assign block_words[gi] = core_block_i[gi*32 +: 32];
    end
    assign sel_word = block_words[WORD_SEL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            msg_reg    <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            start_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            msg_reg    <= msg_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
            start_reg  <= start_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        msg_next    = msg_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        rvalid_next = 1'b0;
        start_next  = 1'b0;
        busy_o      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Late done strobes after a flush land here and are dropped.
                busy_o = req_i & ~flush_i;
                if (req_i && !flush_i) begin
                    msg_next   = op_i;
                    start_next = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                busy_o = ~flush_i;
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy_o = ~flush_i;
                if (flush_i) begin
                    state_next = IDLE;
                end else if (core_done_i) begin
                    // Done beats the timeout when both land in the same cycle.
                    rdata_next  = sel_word;
                    err_next    = 1'b0;
                    rvalid_next = 1'b1;
                    state_next  = RESP;
                end else if (cnt_reg == '0) begin
                    rdata_next  = '0;
                    err_next    = 1'b1;
                    rvalid_next = 1'b1;
                    state_next  = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign msg_o        = msg_reg;
    assign rdata_o      = rdata_reg;
    assign rvalid_o     = rvalid_reg;
    assign err_o        = err_reg;
    assign core_start_o = start_reg;

endmodule

// File: tb/tb_sm4_issue_ctrl.sv
// Bench for sm4_issue_ctrl: two instances (word 3 / 64-cycle timeout, word 0 / 4-cycle timeout)
// checked cycle by cycle against a transaction-level timing model.
module tb_sm4_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req    [2];
    logic         flush  [2];
    logic         done   [2];
    logic [31:0]  op     [2];
    logic [127:0] blk    [2];
    logic         busy   [2];
    logic         rvalid [2];
    logic         err    [2];
    logic         start  [2];
    logic [31:0]  rdata  [2];
    logic [31:0]  msg    [2];

    int passed = 0;
    int total  = 0;
    logic [31:0] msg_model [2];

    sm4_issue_ctrl #(.RESULT_WORD(3), .TIMEOUT_CYCLES(64), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .op_i(op[0]), .flush_i(flush[0]),
        .busy_o(busy[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .msg_o(msg[0]), .core_start_o(start[0]), .core_done_i(done[0]), .core_block_i(blk[0])
    );

    sm4_issue_ctrl #(.RESULT_WORD(0), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .op_i(op[1]), .flush_i(flush[1]),
        .busy_o(busy[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .msg_o(msg[1]), .core_start_o(start[1]), .core_done_i(done[1]), .core_block_i(blk[1])
    );

    function automatic int rw_of(input int u);
        return (u == 0) ? 3 : 0;
    endfunction

    function automatic int to_of(input int u);
        return (u == 0) ? 64 : 4;
    endfunction

    // One request on instance u. Cycle 0 is the acceptance cycle. k = cycle of the done
    // strobe (-1 never), f = flush cycle (-1 none), early = extra done during LAUNCH.
    task automatic run_op(input int u, input logic [31:0] opv, input logic [127:0] blkv,
                          input int k, input int f, input bit early, input int tail);
        int rv, last, tmo;
        bit ok, aborted;
        logic [31:0] word, oldm, expm, expd;
        logic expb, exps, expv, expe;
        tmo  = to_of(u);
        word = 32'(blkv >> (32 * rw_of(u)));
        if (k >= 2 && k <= tmo + 1) begin
            rv = k + 1; ok = 1'b1;
        end else begin
            rv = tmo + 2; ok = 1'b0;
        end
        aborted = (f >= 0);
        last = aborted ? (((k > f) ? k : f) + 1) : (rv + tail);
        oldm = msg_model[u];
        if (f != 0) msg_model[u] = opv;
        for (int cyc = 0; cyc <= last; cyc++) begin
            @(posedge clk); #1;
            req[u]   = aborted ? (cyc <= f) : (cyc <= rv);
            op[u]    = (cyc == 0) ? opv : $urandom();
            flush[u] = (cyc == f);
            done[u]  = (cyc == k) || (early && cyc == 1);
            blk[u]   = (cyc == k) ? blkv : {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            expb = aborted ? (cyc < f) : (cyc < rv);
            exps = (cyc == 1) && (f != 0);
            expv = !aborted && (cyc == rv);
            expe = expv && !ok;
            expm = (cyc == 0 || f == 0) ? oldm : opv;
            expd = ok ? word : 32'h0;
            total++;
            if (busy[u] !== expb) $display("FAIL busy u%0d cyc%0d got %b want %b", u, cyc, busy[u], expb);
            else passed++;
            total++;
            if (start[u] !== exps) $display("FAIL start u%0d cyc%0d got %b want %b", u, cyc, start[u], exps);
            else passed++;
            total++;
            if (rvalid[u] !== expv) $display("FAIL rvalid u%0d cyc%0d got %b want %b", u, cyc, rvalid[u], expv);
            else passed++;
            total++;
            if (err[u] !== expe) $display("FAIL err u%0d cyc%0d got %b want %b", u, cyc, err[u], expe);
            else passed++;
            total++;
            if (msg[u] !== expm) $display("FAIL msg u%0d cyc%0d got %h want %h", u, cyc, msg[u], expm);
            else passed++;
            if (expv) begin
                total++;
                if (rdata[u] !== expd) $display("FAIL rdata u%0d cyc%0d got %h want %h", u, cyc, rdata[u], expd);
                else passed++;
            end
        end
        done[u]  = 1'b0;
        flush[u] = 1'b0;
        $display("txn u%0d op=%h done_cyc=%0d flush_cyc=%0d rvalid_cyc=%0d err=%0b",
                 u, opv, k, f, aborted ? -1 : rv, !ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; flush[u] = 1'b0; done[u] = 1'b0; op[u] = '0; blk[u] = '0;
            msg_model[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({busy[u], rvalid[u], err[u], start[u], msg[u], rdata[u]} !== 68'h0)
                $display("FAIL reset_state u%0d got %b%b%b%b %h %h want all zero",
                         u, busy[u], rvalid[u], err[u], start[u], msg[u], rdata[u]);
            else passed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({busy[u], rvalid[u], err[u], start[u], msg[u]} !== 36'h0)
                $display("FAIL post_reset_idle u%0d got %b%b%b%b %h want all zero",
                         u, busy[u], rvalid[u], err[u], start[u], msg[u]);
            else passed++;
        end
    endtask

    task automatic test_basic();
        run_op(0, 32'h01234567, 128'h681EDF34_D206965E_86B3E94F_536E4246, 6, -1, 1'b0, 1);
    endtask

    task automatic test_timeout();
        run_op(1, 32'h0BADF00D, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, -1, 1'b0, 1);
    endtask

    task automatic test_collision();
        run_op(1, 32'h5A5A0001, {96'h01020304_05060708_090A0B0C, 32'hDEADBEEF}, 5, -1, 1'b0, 1);
    endtask

    task automatic test_flush();
        run_op(0, 32'h13579BDF, 128'h11112222_33334444_55556666_77778888, 5, 3, 1'b0, 0);
        run_op(0, 32'hCAFEF00D, 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4, 4, -1, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        run_op(0, 32'h11111111, 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004, 3, -1, 1'b0, 0);
        run_op(0, 32'h22222222, 128'h9999000F_8888000E_7777000D_6666000C, 4, -1, 1'b1, 1);
    endtask

    task automatic test_async_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); #1;
            req[0] = 1'b1;
            op[0]  = (cyc == 0) ? 32'hA5A5A5A5 : $urandom();
        end
        @(posedge clk); #2;
        total++;
        if (busy[0] !== 1'b1) $display("FAIL async_pre_busy got %b want 1", busy[0]);
        else passed++;
        rst_n  = 1'b0;
        req[0] = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({busy[u], rvalid[u], err[u], start[u], msg[u], rdata[u]} !== 68'h0)
                $display("FAIL async_reset u%0d got %b%b%b%b %h %h want all zero",
                         u, busy[u], rvalid[u], err[u], start[u], msg[u], rdata[u]);
            else passed++;
            msg_model[u] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            done[0] = (cyc == 1);
            @(negedge clk);
            total++;
            if ({busy[0], rvalid[0], start[0], msg[0]} !== 35'h0)
                $display("FAIL async_after u0 cyc%0d got %b%b%b %h want all zero",
                         cyc, busy[0], rvalid[0], start[0], msg[0]);
            else passed++;
        end
        done[0] = 1'b0;
        $display("txn u0 async reset during WAIT");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int u, tmo, k, rvt, f;
            bit early;
            u   = $urandom_range(0, 1);
            tmo = to_of(u);
            if (u == 1) k = $urandom_range(1, tmo + 3);
            else k = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, 12);
            rvt   = (k >= 2 && k <= tmo + 1) ? k + 1 : tmo + 2;
            f     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rvt - 1) : -1;
            early = ($urandom_range(0, 3) == 0);
            run_op(u, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()},
                   k, f, early, $urandom_range(1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_collision();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
